des_input_loader: RTL and testbench

- Receiving end of the DES datapath: the counterpart to the output permutation stage (FP with L/R swap).
- Collects a 64-bit plaintext/ciphertext block over a byte-serial valid/ready interface.
- Applies the DES initial permutation (IP) and presents L0/R0 plus the mode bit to the round engine over a valid/ready handshake.
- Double-buffered: the next block is collected while the current one waits for the round engine.

---
 rtl/des_input_loader.sv | 102 ++++++++++
 tb/tb_des_input_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_input_loader.sv
// Byte-serial DES block loader: assembles 64 bits, applies the initial permutation,
// and hands L0/R0 plus the mode bit to the round engine. Double-buffered.
module des_input_loader #(
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic        mode_in,
    output logic [31:0] L0,
    output logic [31:0] R0,
    output logic        blk_mode,
    output logic        blk_valid,
    input  logic        blk_ready
);

    logic [2:0]  cnt_q, cnt_d;
    logic [63:0] buf_q, buf_d;
    logic        mode_q, mode_d;
    logic        vld_q, vld_d;
    logic [31:0] l0_q, l0_d;
    logic [31:0] r0_q, r0_d;
    logic        bmode_q, bmode_d;

    logic        xfer;
    logic [2:0]  grp;
    logic [63:0] asm_v;
    logic [63:0] ip_out;

    // Only the completing byte can stall: bytes 0-6 of the next block always land
    assign byte_ready = !(cnt_q == 3'd7 && vld_q && !blk_ready);
    assign xfer       = byte_valid && byte_ready;

    // Collect vector bit 63 is DES bit 1; grp selects which byte lane this transfer fills
    assign grp = LSB_FIRST ? cnt_q : 3'd7 - cnt_q;

    always_comb begin
        asm_v = buf_q;
        asm_v[{grp, 3'b000} +: 8] = byte_in;
    end

    // IP wiring: rows 1-4 start at 58,60,62,64 and rows 5-8 at 57,59,61,63, stepping down by 8
    for (genvar i = 0; i < 64; i++) begin : g_ip
        localparam int P = (i < 32) ? 58 + 2 * (i / 8) - 8 * (i % 8)
                                    : 57 + 2 * (i / 8 - 4) - 8 * (i % 8);
        assign ip_out[63 - i] = asm_v[64 - P];
    end

    always_comb begin
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        mode_d  = mode_q;
        vld_d   = vld_q;
        l0_d    = l0_q;
        r0_d    = r0_q;
        bmode_d = bmode_q;

        if (xfer) begin
            buf_d = asm_v;
            cnt_d = 3'(cnt_q + 3'd1);
            if (cnt_q == 3'd0) mode_d = mode_in;
        end

        if (vld_q && blk_ready) vld_d = 1'b0;

        // A completion on the same edge as an accept overrides the clear above
        if (xfer && cnt_q == 3'd7) begin
            vld_d   = 1'b1;
            l0_d    = ip_out[63:32];
            r0_d    = ip_out[31:0];
            bmode_d = mode_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q   <= 3'd0;
            buf_q   <= 64'd0;
            mode_q  <= 1'b0;
            vld_q   <= 1'b0;
            l0_q    <= 32'd0;
            r0_q    <= 32'd0;
            bmode_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            mode_q  <= mode_d;
            vld_q   <= vld_d;
            l0_q    <= l0_d;
            r0_q    <= r0_d;
            bmode_q <= bmode_d;
        end
    end

    assign L0        = l0_q;
    assign R0        = r0_q;
    assign blk_mode  = bmode_q;
    assign blk_valid = vld_q;

endmodule

// File: tb/tb_des_input_loader.sv
// Bench for des_input_loader: both byte orders driven by one stream, checked against
// a queue-based block model with table-driven IP and its inverse for the round trip.
module tb_des_input_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        mode_in;
    logic        blk_ready;
    logic        rdy_a, rdy_b, vld_a, vld_b, md_a, md_b;
    logic [31:0] l0_a, r0_a, l0_b, r0_b;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    des_input_loader #(.LSB_FIRST(1'b0)) dut_a (
        .clk(clk), .reset_n(reset_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(rdy_a), .mode_in(mode_in), .L0(l0_a), .R0(r0_a),
        .blk_mode(md_a), .blk_valid(vld_a), .blk_ready(blk_ready));

    des_input_loader #(.LSB_FIRST(1'b1)) dut_b (
        .clk(clk), .reset_n(reset_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(rdy_b), .mode_in(mode_in), .L0(l0_b), .R0(r0_b),
        .blk_mode(md_b), .blk_valid(vld_b), .blk_ready(blk_ready));

    int ipt [64] = '{58,50,42,34,26,18,10,2,  60,52,44,36,28,20,12,4,
                     62,54,46,38,30,22,14,6,  64,56,48,40,32,24,16,8,
                     57,49,41,33,25,17, 9,1,  59,51,43,35,27,19,11,3,
                     61,53,45,37,29,21,13,5,  63,55,47,39,31,23,15,7};

    function automatic logic [63:0] ip(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63 - i] = x[64 - ipt[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[64 - ipt[i]] = x[63 - i];
        return y;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a byte list for the block in progress and a queue of finished blocks
    typedef struct { logic [63:0] x_a; logic [63:0] x_b; logic m; } blk_t;
    blk_t        q[$];
    logic [7:0]  cur[$];
    logic        cur_m;
    logic        exp_rdy;
    logic [63:0] e_a, e_b, xa, xb;
    int          cyc = 0;
    int          n_acc = 0;
    int          n_stall = 0;
    int          last_acc = -1;
    bit          streaming = 0;
    bit          rnd_rdy = 0;

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            q.delete();
            cur.delete();
        end else begin
            exp_rdy = !(cur.size() == 7 && q.size() != 0 && !blk_ready);
            chk("byte_ready_a", rdy_a, exp_rdy);
            chk("byte_ready_b", rdy_b, exp_rdy);
            chk("blk_valid_a", vld_a, q.size() != 0);
            chk("blk_valid_b", vld_b, q.size() != 0);
            if (q.size() != 0) begin
                e_a = ip(q[0].x_a);
                e_b = ip(q[0].x_b);
                chk("L0_a", l0_a, e_a[63:32]);
                chk("R0_a", r0_a, e_a[31:0]);
                chk("L0_b", l0_b, e_b[63:32]);
                chk("R0_b", r0_b, e_b[31:0]);
                chk("mode_a", md_a, q[0].m);
                chk("mode_b", md_b, q[0].m);
            end
            if (vld_a && blk_ready) begin
                n_acc++;
                if (streaming && last_acc >= 0) chk("stream_spacing", cyc - last_acc, 8);
                last_acc = cyc;
                if (q.size() != 0) begin
                    chk("roundtrip_a", fp({l0_a, r0_a}), q[0].x_a);
                    chk("roundtrip_b", fp({l0_b, r0_b}), q[0].x_b);
                    q.pop_front();
                end
            end
            if (byte_valid && !exp_rdy) n_stall++;
            if (byte_valid && exp_rdy) begin
                if (cur.size() == 0) cur_m = mode_in;
                cur.push_back(byte_in);
                if (cur.size() == 8) begin
                    for (int k = 0; k < 8; k++) begin
                        xa[63 - 8 * k -: 8] = cur[k];
                        xb[8 * k + 7 -: 8]  = cur[k];
                    end
                    q.push_back('{x_a: xa, x_b: xb, m: cur_m});
                    cur.delete();
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic m);
        int  t;
        logic ok;
        t = 0;
        byte_in = b;
        mode_in = m;
        byte_valid = 1'b1;
        do begin
            if (rnd_rdy) blk_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            ok = rdy_a;
            tick();
            t++;
        end while (!ok && t < 200);
        if (!ok) chk("byte_timeout", 0, 1);
        byte_valid = 1'b0;
    endtask

    task automatic send_blk(input logic [63:0] x, input logic m);
        for (int k = 0; k < 8; k++)
            send_byte(x[63 - 8 * k -: 8], (k == 0) ? m : 1'($urandom));
    endtask

    task automatic idle(input int n);
        byte_valid = 1'b0;
        repeat (n) begin
            if (rnd_rdy) blk_ready = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    logic [63:0] rx, ev;
    int a0, s0, sent;

    initial begin
        reset_n = 1'b0; byte_in = 8'h00; byte_valid = 1'b0; mode_in = 1'b0; blk_ready = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_byte_ready", rdy_a, 1);
        chk("rst_blk_valid", vld_a, 0);
        chk("rst_L0", l0_a, 0);
        chk("rst_R0", r0_a, 0);
        chk("rst_mode", md_a, 0);
        tick();

        // Known-answer block, both byte orders
        blk_ready = 1'b1;
        send_blk(64'h0123456789ABCDEF, 1'b0);
        @(negedge clk);
        chk("kat_valid", vld_a, 1);
        chk("kat_L0", l0_a, 32'hCC00CCFF);
        chk("kat_R0", r0_a, 32'hF0AAF0AA);
        chk("kat_mode", md_a, 0);
        ev = ip(64'hEFCDAB8967452301);
        chk("kat_L0_lsbfirst", l0_b, ev[63:32]);
        tick();
        @(negedge clk);
        chk("kat_valid_clear", vld_a, 0);
        tick();

        send_blk(64'hEFCDAB8967452301, 1'b0);
        @(negedge clk);
        chk("rev_L0_lsbfirst", l0_b, 32'hCC00CCFF);
        chk("rev_R0_lsbfirst", r0_b, 32'hF0AAF0AA);
        tick();
        tick();

        // Backpressure: A held, B's completing byte stalls until A is taken
        blk_ready = 1'b0;
        send_blk(64'h0123456789ABCDEF, 1'b0);
        for (int k = 0; k < 7; k++) send_byte(8'hFF, (k == 0) ? 1'b1 : 1'b0);
        byte_in = 8'hFF; mode_in = 1'b0; byte_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("stall_ready", rdy_a, 0);
            chk("stall_L0_A", l0_a, 32'hCC00CCFF);
            chk("stall_R0_A", r0_a, 32'hF0AAF0AA);
            tick();
        end
        blk_ready = 1'b1;
        @(negedge clk);
        chk("unstall_ready", rdy_a, 1);
        tick();
        byte_valid = 1'b0;
        @(negedge clk);
        chk("b2b_valid", vld_a, 1);
        chk("b2b_L0", l0_a, 32'hFFFFFFFF);
        chk("b2b_R0", r0_a, 32'hFFFFFFFF);
        chk("b2b_mode", md_a, 1);
        tick();
        tick();

        // Streaming: four blocks, no gaps
        a0 = n_acc; s0 = n_stall; last_acc = -1; streaming = 1;
        for (int b = 0; b < 4; b++) send_blk({$urandom, $urandom}, 1'($urandom));
        @(negedge clk);
        tick();
        streaming = 0;
        chk("stream_pulses", n_acc - a0, 4);
        chk("stream_no_stall", n_stall - s0, 0);

        // Reset with a held block and a partial one in flight
        blk_ready = 1'b0;
        send_blk({$urandom, $urandom}, 1'b1);
        for (int k = 0; k < 5; k++) send_byte(8'($urandom), 1'b1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("midrst_valid", vld_a, 0);
        chk("midrst_L0", l0_a, 0);
        chk("midrst_R0", r0_a, 0);
        tick();
        blk_ready = 1'b1;
        rx = {$urandom, $urandom};
        send_blk(rx, 1'b0);
        @(negedge clk);
        ev = ip(rx);
        chk("postrst_L0", l0_a, ev[63:32]);
        chk("postrst_R0", r0_a, ev[31:0]);
        tick();
        tick();

        // Random blocks with random gaps and random output backpressure
        a0 = n_acc; sent = 0; rnd_rdy = 1;
        for (int b = 0; b < 1000; b++) begin
            send_blk({$urandom, $urandom}, 1'($urandom));
            sent++;
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rnd_rdy = 0;
        blk_ready = 1'b1;
        idle(4);
        chk("random_accepts", n_acc - a0, sent);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
